// File: rtl/lcd_pkg.sv
// Shared opcode constants, limits and sequencer state encoding for the LCD
// command path.
package lcd_pkg;

  localparam logic [3:0] CMD_WRITE      = 4'd0;
  localparam logic [3:0] CMD_SHIFT_UP   = 4'd1;
  localparam logic [3:0] CMD_SHIFT_DOWN = 4'd2;
  localparam logic [3:0] CMD_SHIFT_LEFT = 4'd3;
  localparam logic [3:0] CMD_SHIFT_RGHT = 4'd4;
  localparam logic [3:0] CMD_MAX        = 4'd5;
  localparam logic [3:0] CMD_MIN        = 4'd6;
  localparam logic [3:0] CMD_AVERAGE    = 4'd7;
  localparam logic [3:0] CMD_ROT_CCW    = 4'd8;
  localparam logic [3:0] CMD_ROT_CW     = 4'd9;
  localparam logic [3:0] CMD_MIRROR_X   = 4'd10;
  localparam logic [3:0] CMD_MIRROR_Y   = 4'd11;

  localparam int unsigned MAX_CMD = 11;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_IDLE,
    ST_GUARD,
    ST_WAIT,
    ST_FLUSH,
    ST_DONE
  } state_t;

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; pointers wrap modulo DEPTH.
module lcd_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/lcd_cmd_seq.sv
// Host-to-engine command sequencer: buffers host opcodes and issues them one
// at a time as single-cycle strobes, gated on the engine's busy signal.
module lcd_cmd_seq
  import lcd_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MAX_CMD = lcd_pkg::MAX_CMD,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [3:0]               host_cmd,
  input  logic                     host_valid,
  output logic                     host_ready,
  output logic [3:0]               lcd_cmd,
  output logic                     lcd_cmd_valid,
  input  logic                     lcd_busy,
  input  logic                     lcd_done,
  output logic                     seq_done,
  output logic                     err_cmd,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         cmd_count
);

  localparam logic [3:0] MAX_OP = 4'(MAX_CMD);

  state_t     state;
  state_t     state_nx;
  logic       closed;
  logic       full;
  logic       empty;
  logic [3:0] head;
  logic       xfer;
  logic       legal;
  logic       push;
  logic       issue;

  // Closing intake once a write is queued also covers FLUSH/DONE, since the
  // only way there is by issuing that write.
  assign host_ready = !full && !closed;
  assign xfer       = host_valid && host_ready;
  assign legal      = (host_cmd <= MAX_OP);
  assign push       = xfer && legal;
  assign seq_done   = (state == ST_DONE);

  lcd_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (4)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (issue),
    .din     (host_cmd),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_BOOT;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    case (state)
      ST_BOOT:  if (!lcd_busy) state_nx = ST_IDLE;
      ST_IDLE: begin
        if (!empty && !lcd_busy) begin
          issue    = 1'b1;
          state_nx = ST_GUARD;
        end
      end
      // The engine raises busy a cycle after the strobe, so busy is not
      // trusted here.
      ST_GUARD: state_nx = (lcd_cmd == CMD_WRITE) ? ST_FLUSH : ST_WAIT;
      ST_WAIT:  if (!lcd_busy) state_nx = ST_IDLE;
      ST_FLUSH: if (lcd_done) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_DONE;
      default:  state_nx = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lcd_cmd       <= '0;
      lcd_cmd_valid <= 1'b0;
      cmd_count     <= '0;
      err_cmd       <= 1'b0;
      closed        <= 1'b0;
    end else begin
      lcd_cmd_valid <= issue;
      err_cmd       <= xfer && !legal;
      if (issue) begin
        lcd_cmd <= head;
        if (cmd_count != '1) cmd_count <= cmd_count + 1'b1;
      end
      if (push && (host_cmd == CMD_WRITE)) closed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Scoreboard bench for lcd_cmd_seq: stimulus queues expected issues, a
// monitor pops them on every lcd_cmd_valid strobe alongside a busy-engine model.
module tb_lcd_cmd_seq;
  import lcd_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] host_cmd;
  logic       host_valid;
  logic       host_ready;
  logic [3:0] lcd_cmd;
  logic       lcd_cmd_valid;
  logic       lcd_busy;
  logic       lcd_done;
  logic       seq_done;
  logic       err_cmd;
  logic [2:0] fifo_level;
  logic [7:0] cmd_count;
  logic       boot_busy;
  logic       op_busy;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int exp_issue;
  int err_seen;
  int max_level;
  int cyc;
  int last_issue;
  logic prev_valid;
  logic prev_busy;

  assign lcd_busy = boot_busy | op_busy;

  always #5 clk = ~clk;

  lcd_cmd_seq #(
    .DEPTH   (4),
    .MAX_CMD (11),
    .CNT_W   (8)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .host_cmd      (host_cmd),
    .host_valid    (host_valid),
    .host_ready    (host_ready),
    .lcd_cmd       (lcd_cmd),
    .lcd_cmd_valid (lcd_cmd_valid),
    .lcd_busy      (lcd_busy),
    .lcd_done      (lcd_done),
    .seq_done      (seq_done),
    .err_cmd       (err_cmd),
    .fifo_level    (fifo_level),
    .cmd_count     (cmd_count)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      cyc++;
      if (lcd_cmd_valid) begin
        check("valid_back_to_back", int'(prev_valid), 0);
        check("valid_after_busy", int'(prev_busy), 0);
        if (last_issue >= 0) check("issue_spacing", int'((cyc - last_issue) >= 3), 1);
        last_issue = cyc;
        if (exp_q.size() == 0) check("unexpected_issue", int'(lcd_cmd), -1);
        else check("issued_cmd", int'(lcd_cmd), exp_q.pop_front());
        if (exp_issue < 255) exp_issue++;
        check("cmd_count", int'(cmd_count), exp_issue);
      end
      if (err_cmd) err_seen++;
      if (reset_n) begin
        if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
        if (fifo_level == 3'd4) check("ready_at_full", int'(host_ready), 0);
      end
      prev_valid = lcd_cmd_valid;
      prev_busy  = lcd_busy;
    end
  endtask

  task automatic engine();
    forever begin
      tick();
      if (lcd_cmd_valid) begin
        op_busy = 1'b1;
        repeat (3) tick();
        op_busy = 1'b0;
      end
    end
  endtask

  task automatic send(input int c);
    int n = 0;
    while (!host_ready && n < 50) begin
      tick();
      n++;
    end
    check("send_ready", int'(host_ready), 1);
    host_valid = 1'b1;
    host_cmd   = 4'(c);
    if (c <= 11) exp_q.push_back(c);
    tick();
    host_valid = 1'b0;
    check("err_cmd_pulse", int'(err_cmd), int'(c > 11));
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      tick();
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic settle();
    int n = 0;
    while (op_busy && n < 20) begin
      tick();
      n++;
    end
    repeat (3) tick();
  endtask

  initial begin
    int n;
    int base;
    host_valid = 1'b0;
    host_cmd   = '0;
    lcd_done   = 1'b0;
    boot_busy  = 1'b1;
    op_busy    = 1'b0;
    exp_issue  = 0;
    err_seen   = 0;
    max_level  = 0;
    cyc        = 0;
    last_issue = -1;
    prev_valid = 1'b0;
    prev_busy  = 1'b0;
    fork
      monitor();
      engine();
    join_none

    repeat (3) tick();
    reset_n = 1'b1;
    check("rst_valid", int'(lcd_cmd_valid), 0);
    check("rst_cmd", int'(lcd_cmd), 0);
    check("rst_seq_done", int'(seq_done), 0);
    check("rst_err", int'(err_cmd), 0);
    check("rst_level", int'(fifo_level), 0);
    check("rst_count", int'(cmd_count), 0);
    check("rst_ready", int'(host_ready), 1);

    // Boot gating: engine busy for ~64 cycles after reset
    repeat (5) tick();
    send(1);
    repeat (58) tick();
    check("boot_no_issue", exp_issue, 0);
    check("boot_level", int'(fifo_level), 1);
    boot_busy = 1'b0;
    n = 0;
    while (!lcd_cmd_valid && n < 10) begin
      tick();
      n++;
    end
    check("boot_issue_latency", n, 2);
    drain(5);
    settle();

    // Fill and backpressure; a stray lcd_done must be ignored
    max_level = 0;
    for (int c = 1; c <= 6; c++) send(c);
    lcd_done = 1'b1;
    tick();
    lcd_done = 1'b0;
    drain(200);
    settle();
    check("fill_peak_level", max_level, 4);
    check("stray_done_ignored", int'(seq_done), 0);

    // Illegal opcodes
    max_level = 0;
    base = err_seen;
    send(12);
    send(15);
    send(3);
    drain(50);
    settle();
    check("err_pulse_count", err_seen - base, 2);
    check("illegal_peak_level", max_level, 1);

    // Write closure
    send(7);
    send(0);
    check("closed_ready", int'(host_ready), 0);
    host_valid = 1'b1;
    host_cmd   = 4'd5;
    repeat (3) begin
      tick();
      check("closed_no_accept", int'(host_ready), 0);
    end
    host_valid = 1'b0;
    drain(100);
    repeat (3) tick();
    check("flush_state", int'(dut.state), int'(ST_FLUSH));
    check("flush_level", int'(fifo_level), 0);
    check("flush_not_done", int'(seq_done), 0);
    lcd_done = 1'b1;
    tick();
    lcd_done = 1'b0;
    check("seq_done_set", int'(seq_done), 1);
    repeat (5) tick();
    check("seq_done_sticky", int'(seq_done), 1);
    check("done_ready", int'(host_ready), 0);

    // Simultaneous push/pop at level 2
    #2;
    reset_n   = 1'b0;
    boot_busy = 1'b1;
    exp_q.delete();
    exp_issue  = 0;
    last_issue = -1;
    tick();
    tick();
    reset_n   = 1'b1;
    boot_busy = 1'b0;
    tick();
    boot_busy = 1'b1;
    send(9);
    send(10);
    check("preload_level", int'(fifo_level), 2);
    for (int i = 0; i < 10; i++) begin
      n = 0;
      while (op_busy && n < 20) begin
        tick();
        n++;
      end
      boot_busy = 1'b0;
      n = 0;
      while (dut.state != ST_IDLE && n < 10) begin
        tick();
        n++;
      end
      host_cmd   = 4'((i % 11) + 1);
      host_valid = 1'b1;
      exp_q.push_back((i % 11) + 1);
      tick();
      host_valid = 1'b0;
      boot_busy  = 1'b1;
      check("pushpop_level", int'(fifo_level), 2);
      check("pushpop_issue", int'(lcd_cmd_valid), 1);
    end
    boot_busy = 1'b0;
    drain(100);
    settle();

    // Async reset while in WAIT with 3 entries queued
    boot_busy = 1'b1;
    send(2);
    send(3);
    send(4);
    send(5);
    check("pre_reset_level", int'(fifo_level), 4);
    boot_busy = 1'b0;
    tick();
    boot_busy = 1'b1;
    check("pre_reset_issue", int'(lcd_cmd_valid), 1);
    tick();
    tick();
    check("pre_reset_wait", int'(dut.state), int'(ST_WAIT));
    check("pre_reset_level3", int'(fifo_level), 3);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", int'(lcd_cmd_valid), 0);
    check("async_rst_level", int'(fifo_level), 0);
    check("async_rst_count", int'(cmd_count), 0);
    exp_q.delete();
    exp_issue  = 0;
    last_issue = -1;
    tick();
    tick();
    reset_n = 1'b1;
    check("post_rst_ready", int'(host_ready), 1);
    check("post_rst_boot", int'(dut.state), int'(ST_BOOT));
    check("post_rst_done", int'(seq_done), 0);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_cmd_seq.md
Name: lcd_cmd_seq

Overview:
Command sequencer between a host command source and the LCD image engine, which holds an 8x8 buffer and runs 2x2-window operations. It accepts host commands over a valid/ready handshake and buffers them in a small FIFO. It issues each command to the engine as a single-cycle cmd_valid pulse, only when the engine's busy is low, and tracks the engine through image load, operations and final write-out. It closes intake once a write command (0) is queued and reports completion when the engine raises done.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, >=2)
MAX_CMD, 11, highest legal opcode; opcodes above it are rejected
CNT_W, 8, width of the issued-command counter (saturating)

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
host_cmd  in  4  opcode from host
host_valid  in  1  host_cmd valid
host_ready  out  1  sequencer can accept host_cmd this cycle
lcd_cmd  out  4  opcode to engine (registered)
lcd_cmd_valid  out  1  one-cycle issue strobe to engine (registered)
lcd_busy  in  1  engine busy (high during image load, op, write-out)
lcd_done  in  1  engine finished image write-out
seq_done  out  1  sticky completion flag
err_cmd  out  1  one-cycle pulse: illegal opcode accepted and dropped
fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy
cmd_count  out  CNT_W  commands issued to engine, saturates at all-ones

Behaviour:
- Clock and reset: one clock (clk); reset_n is asynchronous, active-low.
- Reset values:
  - All outputs 0 except host_ready, which is 1 once reset is released and the FIFO is empty.
  - FIFO is emptied, intake is open, state is BOOT.
- host_ready = !full && !closed, driven from registered state only, with no pop lookahead.
  - A transfer occurs when host_valid && host_ready.
- Opcode handling on transfer:
  - Opcode <= MAX_CMD: pushed to the FIFO.
  - Opcode > MAX_CMD: not pushed; err_cmd pulses in the next cycle.
  - Opcode 0 pushed: closed is set, so host_ready = 0 from the next cycle until reset.
- Simultaneous push and pop: occupancy is unchanged. The pointers wrap modulo DEPTH.
- State machine:
  - BOOT: waits for lcd_busy to fall after the engine's image load. A 0 sample with no preceding 1 also counts. Goes to IDLE when lcd_busy == 0.
  - IDLE: if the FIFO is non-empty and lcd_busy == 0:
    - register lcd_cmd = head and lcd_cmd_valid = 1;
    - pop the head and increment cmd_count (saturating);
    - go to GUARD.
  - GUARD: one cycle; lcd_cmd_valid returns to 0 and lcd_busy is ignored. Goes to FLUSH if the issued opcode was 0, otherwise to WAIT.
  - WAIT: goes to IDLE when lcd_busy == 0.
  - FLUSH: no further issue, and the FIFO is frozen (it is empty by construction). Goes to DONE when lcd_done == 1.
  - DONE: seq_done = 1, host_ready = 0, and no issue. Terminal until reset.
- Issue latency: at least 1 cycle from a push into an empty FIFO to lcd_cmd_valid. Back-to-back issues are at least 3 cycles apart (IDLE, GUARD, WAIT minimum).
- lcd_cmd_valid is never high on two consecutive cycles, and is never high while the previous cycle's lcd_busy was 1.
- lcd_done seen in any state other than FLUSH is ignored.
- Reset mid-operation: the FIFO contents are discarded, and lcd_cmd_valid drops asynchronously.

Decomposition:
- Shared package lcd_pkg holds:
  - the opcode constants CMD_WRITE = 0 through CMD_MIRROR_Y = 11;
  - MAX_CMD;
  - the state enum.
- One sub-module, lcd_cmd_fifo: a synchronous FIFO with parameter DEPTH, push/pop, full/empty and level outputs.
- The sequencer FSM, counter and error logic sit in the top level.

Test Plan:
1. Boot gating: hold lcd_busy = 1 for 64 cycles, push cmd 1 at cycle 5 -> no lcd_cmd_valid until the cycle after lcd_busy falls; then one pulse with lcd_cmd = 1 and cmd_count = 1.
2. Fill and backpressure: with the engine idle and lcd_busy modelled as 1 for 3 cycles per op, push 6 commands (1,2,3,4,5,6) back-to-back -> host_ready drops when fifo_level = 4; issue order is 1..6 with pulses at least 3 cycles apart; the level never exceeds 4.
3. Illegal opcode: push 12, then 15, then 3 -> err_cmd pulses twice; fifo_level peaks at 1; only opcode 3 is issued.
4. Write closure: push 7, 0, 5 -> host_ready = 0 the cycle after 0 is accepted, so 5 is not accepted. 7 then 0 are issued; state is FLUSH. Drive lcd_done = 1 -> seq_done = 1 the next cycle and stays high.
5. Simultaneous push/pop at level 2 -> level stays at 2 and the pointer wrap is correct across 10 iterations.
6. Async reset asserted while in WAIT with 3 entries queued -> lcd_cmd_valid = 0, fifo_level = 0 and cmd_count = 0 immediately. After release the sequencer is in BOOT and host_ready = 1.
